// File: rtl/adma_data_fifo_pkg.sv
// Shared constants for the ADMA data FIFO: default geometry, watermarks
// and the bit positions of the FIFO errors in the host error status register.
package adma_data_fifo_pkg;

    localparam int ADMA_DATA_WIDTH      = 32;
    localparam int ADMA_FIFO_DEPTH_LOG2 = 4;
    localparam int ADMA_AFULL_LVL       = 12;
    localparam int ADMA_AEMPTY_LVL      = 4;

    // Error status register bit indices driven from the sticky FIFO flags.
    localparam int ADMA_ERR_FIFO_OVERFLOW_BIT  = 0;
    localparam int ADMA_ERR_FIFO_UNDERFLOW_BIT = 1;

endpackage

// File: rtl/adma_data_fifo_mem.sv
// Register file backing the ADMA data FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module adma_data_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word in the addressed slot.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adma_data_fifo.sv
// Synchronous first-word-fall-through data FIFO between the ADMA engine and
// the SD data-line (de)serializer. Pointers wrap naturally at the depth;
// a separate level counter drives all status flags. Overflow/underflow are
// sticky until clear_errors.
//
// Handshake: there is no backpressure. A push happens on fifo_write when
// the FIFO is not full or is popped in the same cycle; a pop happens on
// fifo_read when the FIFO is not empty. Requests that cannot be honoured
// are dropped and recorded in the sticky error flags.
module adma_data_fifo
    import adma_data_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = ADMA_DATA_WIDTH,
    parameter int DEPTH_LOG2 = ADMA_FIFO_DEPTH_LOG2,
    parameter int AFULL_LVL  = ADMA_AFULL_LVL,
    parameter int AEMPTY_LVL = ADMA_AEMPTY_LVL
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  fifo_write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  flush,
    input  logic                  clear_errors
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(2 ** DEPTH_LOG2);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LVL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LVL);

    logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr, rd_ptr_next;
    logic [LW-1:0]         level_q, level_next;
    logic                  overflow_q, overflow_next;
    logic                  underflow_q, underflow_next;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  overflow_set;
    logic                  underflow_set;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Status flags are pure decodes of the level counter.
    assign fifo_full    = (level_q == DEPTH_L);
    assign fifo_empty   = (level_q == '0);
    assign almost_full  = (level_q >= AFULL_L);
    assign almost_empty = (level_q <= AEMPTY_L);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A push into a full FIFO is legal when a pop frees the head slot this cycle.
    assign wr_accept     = fifo_write && (!fifo_full || fifo_read);
    assign rd_accept     = fifo_read && !fifo_empty;
    // Requests swallowed by a flush are discarded, not reported as errors.
    assign overflow_set  = !flush && fifo_write && fifo_full && !fifo_read;
    assign underflow_set = !flush && fifo_read && fifo_empty;

    assign mem_we   = wr_accept && !flush && !RESET;
    assign data_out = fifo_empty ? '0 : mem_rdata;

    adma_data_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .CLK   (CLK),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Next-state for pointers, level and sticky errors; flush overrides push/pop.
    always_comb begin
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        level_next     = level_q;
        overflow_next  = (overflow_q && !clear_errors) || overflow_set;
        underflow_next = (underflow_q && !clear_errors) || underflow_set;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_next = wr_ptr + DEPTH_LOG2'(1);
            end
            if (rd_accept) begin
                rd_ptr_next = rd_ptr + DEPTH_LOG2'(1);
            end
            if (wr_accept && !rd_accept) begin
                level_next = level_q + LW'(1);
            end else if (rd_accept && !wr_accept) begin
                level_next = level_q - LW'(1);
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            level_q     <= level_next;
            overflow_q  <= overflow_next;
            underflow_q <= underflow_next;
        end
    end

endmodule

// File: tb/tb_adma_data_fifo.sv
// Bench for adma_data_fifo: directed scenarios followed by random traffic,
// checked against a queue-based reference model through a scoreboard.
module tb_adma_data_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int EW = DW + 5 + 6;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          fifo_write = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          fifo_read = 1'b0;
    logic          flush = 1'b0;
    logic          clear_errors = 1'b0;
    logic [DW-1:0] data_out;
    logic          fifo_full, fifo_empty, almost_full, almost_empty;
    logic [4:0]    level;
    logic          overflow, underflow;

    adma_data_fifo dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .fifo_write   (fifo_write),
        .data_in      (data_in),
        .fifo_read    (fifo_read),
        .data_out     (data_out),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .flush        (flush),
        .clear_errors (clear_errors)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference model: stored words in order, plus sticky flags
    logic [DW-1:0] model_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    function automatic logic [EW-1:0] model_outputs();
        int n;
        logic [DW-1:0] head;
        n = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        return {head, 5'(n), (n == DEPTH), (n == 0), (n >= 12), (n <= 4), m_ovf, m_unf};
    endfunction

    // Apply one cycle of stimulus, advance the model at the edge, queue expectation.
    task automatic step(input string nm, input logic wr, input logic [DW-1:0] d,
                        input logic rd, input logic fl, input logic ce, input logic rst);
        int  n;
        logic ovf_set, unf_set;
        fifo_write   = wr;
        data_in      = d;
        fifo_read    = rd;
        flush        = fl;
        clear_errors = ce;
        RESET        = rst;
        @(posedge CLK);
        n = model_q.size();
        if (rst) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            ovf_set = !fl && wr && (n == DEPTH) && !rd;
            unf_set = !fl && rd && (n == 0);
            m_ovf = (m_ovf && !ce) || ovf_set;
            m_unf = (m_unf && !ce) || unf_set;
            if (fl) begin
                model_q.delete();
            end else begin
                if (rd && n > 0) void'(model_q.pop_front());
                if (wr && (n < DEPTH || rd)) model_q.push_back(d);
            end
        end
        exp_q.push_back(model_outputs());
        name_q.push_back(nm);
        #1;
    endtask

    // Monitor: compare every queued expectation at the following falling edge
    always @(negedge CLK) begin
        logic [EW-1:0] exp_v, act_v;
        string nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm = name_q.pop_front();
            act_v = {data_out, level, fifo_full, fifo_empty, almost_full, almost_empty,
                     overflow, underflow};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got data=%h lvl=%0d f/e/af/ae/ov/un=%b expected data=%h lvl=%0d f/e/af/ae/ov/un=%b",
                         nm, act_v[EW-1 -: DW], act_v[10:6], act_v[5:0],
                         exp_v[EW-1 -: DW], exp_v[10:6], exp_v[5:0]);
            end
        end
    end

    initial begin
        // Reset and idle
        step("reset", 0, 0, 0, 0, 0, 1);
        step("reset", 0, 0, 0, 0, 0, 1);
        step("idle", 0, 0, 0, 0, 0, 0);

        // Fill with 0x1..0x10
        for (int i = 1; i <= 16; i++) step("fill", 1, DW'(i), 0, 0, 0, 0);
        // Write while full: dropped, overflow
        step("overflow", 1, 32'hDEAD, 0, 0, 0, 0);
        // Drain 16 words
        for (int i = 0; i < 16; i++) step("drain", 0, 0, 1, 0, 0, 0);
        // Extra read while empty with clear: underflow from new error wins
        step("clr_ovf_unf", 0, 0, 1, 0, 1, 0);
        step("clear", 0, 0, 0, 0, 1, 0);

        // Refill, then read+write while full
        for (int i = 0; i < 16; i++) step("refill", 1, 32'h100 + DW'(i), 0, 0, 0, 0);
        step("full_rw", 1, 32'hBEEF, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step("wrap_read", 0, 0, 1, 0, 0, 0);
        step("last_read", 0, 0, 1, 0, 0, 0);

        // Empty read+write together
        step("empty_rw", 1, 32'h55, 1, 0, 0, 0);
        step("clear_unf", 0, 0, 0, 0, 1, 0);

        // Reach level 5, then flush with a concurrent write
        for (int i = 0; i < 4; i++) step("to_five", 1, 32'hA0 + DW'(i), 0, 0, 0, 0);
        step("flush_wr", 1, 32'hF00D, 0, 1, 0, 0);
        step("post_flush", 0, 0, 0, 0, 0, 0);

        // Reset mid-stream of writes
        for (int i = 0; i < 3; i++) step("stream", 1, 32'hC0 + DW'(i), 0, 0, 0, 0);
        step("mid_reset", 1, 32'hDEAD, 0, 0, 0, 1);
        step("after_reset", 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = (i / 300) % 2 == 0 ? 70 : 30;
            step("random",
                 $urandom_range(0, 99) < wp,
                 $urandom(),
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 999) == 0);
        end

        // Let the monitor consume the remaining expectations
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
